// File: rtl/uart_rx_oversampled_pkg.sv
// Shared constants for the oversampled UART receiver: state encoding and the
// default oversampling/frame sizes also used by the baud generator.
package uart_rx_oversampled_pkg;

    localparam int DEF_OVERSAMPLE = 8;
    localparam int DEF_DATA_BITS  = 8;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE  = 3'd0;
    localparam rx_state_t ST_START = 3'd1;
    localparam rx_state_t ST_DATA  = 3'd2;
    localparam rx_state_t ST_STOP  = 3'd3;
    localparam rx_state_t ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_rx_oversampled_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset to
// RESET_VAL so an idle-high line does not look like an edge out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver driven by an oversampling baud tick; samples each bit at
// its centre, strobes rx_valid on good frames and frame_err on a low stop bit.
module uart_rx_oversampled
    import uart_rx_oversampled_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state_q,     state_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [BIT_W-1:0]     bit_idx_q,   bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 rx_valid_q,  rx_valid_d;
    logic                 frame_err_q, frame_err_d;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (rx),
        .q_o  (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        if (baud_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_MID) begin
                        // A start bit that is high again at its centre was a glitch.
                        state_d   = rx_s ? ST_IDLE : ST_DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Hold off until the line goes idle so a long low cannot retrigger.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: frames are queued as they are
// driven and checked (data, kind and tick latency) when a pulse appears.
module tb_uart_rx_oversampled;

    localparam int OS      = 8;
    localparam int DB      = 8;
    localparam int BIT_CLK = OS * 4;
    localparam int LAT     = OS / 2 + OS * (DB + 1);

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    logic [7:0] last_good = 8'h00;

    int   edge_n = 0;
    int   tick_n = 0;
    int   t0_tick = 0;
    int   fall_edge = 0;
    logic t0_pending = 1'b0;
    logic tick_now = 1'b0;
    int   phase = 0;

    uart_rx_oversampled #(
        .OVERSAMPLE(OS),
        .DATA_BITS (DB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_tick(baud_tick),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // baud_tick every 4 clk, changed on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            phase = (phase + 1) % 4;
            baud_tick = (phase == 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: track tick numbering, find T0 of each frame, score every pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edge_n++;
            tick_now = baud_tick;
            if (baud_tick) begin
                tick_n++;
                if (t0_pending && edge_n >= fall_edge + 2) begin
                    t0_tick    = tick_n;
                    t0_pending = 1'b0;
                end
            end
            #1;
            if (rx_valid || frame_err) begin
                check_eq("exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
                check_eq("on_tick", {31'd0, tick_now}, 32'd1);
                check_eq("latency", tick_n - t0_tick, LAT);
                check_eq("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_eq("kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
                    if (e.is_err) begin
                        check_eq("data_kept", {24'd0, rx_data}, {24'd0, last_good});
                        $display("frame_err  kept=0x%02h", rx_data);
                    end else begin
                        check_eq("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                        last_good = e.data;
                        $display("rx_valid   data=0x%02h expected=0x%02h", rx_data, e.data);
                    end
                end
            end
        end
    end

    task automatic hold_rx(input logic v, input int nclk);
        @(negedge clk);
        rx = v;
        repeat (nclk - 1) @(negedge clk);
    endtask

    task automatic start_bit(input int nclk);
        @(negedge clk);
        rx         = 1'b0;
        fall_edge  = edge_n + 1;
        t0_pending = 1'b1;
        repeat (nclk - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        exp_t e;
        e.is_err = ~stop;
        e.data   = data;
        sb_q.push_back(e);
        start_bit(BIT_CLK);
        for (int i = 0; i < DB; i++) hold_rx(data[i], BIT_CLK);
        hold_rx(stop, BIT_CLK);
    endtask

    initial begin
        exp_t e;
        logic [7:0] c3;
        repeat (5) @(negedge clk);
        #1;
        check_eq("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_rx(1'b1, 64);

        // good frame
        send_frame(8'hA5, 1'b1);
        hold_rx(1'b1, 64);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);

        // back-to-back, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold_rx(1'b1, 64);

        // glitch of two ticks
        start_bit(8);
        hold_rx(1'b1, 40);
        check_eq("glitch_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h3C, 1'b1);
        hold_rx(1'b1, 64);

        // framing error: stop bit low, line stays low afterwards
        send_frame(8'h55, 1'b0);
        hold_rx(1'b0, 64);
        check_eq("ferr_busy_held", {31'd0, busy}, 32'd1);
        hold_rx(1'b1, 24);
        check_eq("ferr_busy_clear", {31'd0, busy}, 32'd0);
        hold_rx(1'b1, 40);

        // break: 30 bit-times low
        e.is_err = 1'b1;
        e.data   = 8'h00;
        sb_q.push_back(e);
        start_bit(30 * BIT_CLK);
        check_eq("break_busy", {31'd0, busy}, 32'd1);
        hold_rx(1'b1, 64);
        check_eq("break_idle", {31'd0, busy}, 32'd0);
        send_frame(8'h81, 1'b1);
        hold_rx(1'b1, 64);

        // reset during data bit 3 of 0xC3
        c3 = 8'hC3;
        start_bit(BIT_CLK);
        for (int i = 0; i < 3; i++) hold_rx(c3[i], BIT_CLK);
        hold_rx(c3[3], BIT_CLK / 2);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check_eq("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        check_eq("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        last_good = 8'h00;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        hold_rx(1'b1, 3 * BIT_CLK);
        send_frame(8'h12, 1'b1);
        hold_rx(1'b1, 100);

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

UART receiver that consumes the 8× oversampling `baud_tick` from the baud generator and deserialises the asynchronous `rx` line into bytes (8N1, LSB first). It sits directly downstream of the baud generator and upstream of whatever byte consumer is attached (command decoder or FIFO). It presents each received byte with a one-clock valid strobe and flags framing errors.

## Interface
- `OVERSAMPLE`, 8: baud_tick pulses per bit period; must be even and ≥4.
- `DATA_BITS`, 8: data bits per frame.
- `clk` input 1: system clock (50 MHz nominal).
- `rst_n` input 1: asynchronous, active-low reset.
- `baud_tick` input 1: one-clk pulse at 8× the baud rate from the baud generator.
- `rx` input 1: asynchronous serial line, idle high.
- `rx_data` output DATA_BITS: last correctly framed byte; held until the next good frame.
- `rx_valid` output 1: one-clk pulse when `rx_data` is updated.
- `frame_err` output 1: one-clk pulse when the stop bit samples low.
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised value `rx_s`.
- State, the tick counter (`cnt`, width clog2(OVERSAMPLE)) and the bit index advance only in clk cycles where `baud_tick`=1. Outputs are registered.
- States:
  - IDLE: on a tick with `rx_s`=0, go to START with `cnt`=0.
  - START: count ticks. On the tick where `cnt`==OVERSAMPLE/2−1 (mid-start), go to DATA if `rx_s`=0, otherwise return to IDLE (glitch reject). In both cases `cnt` is cleared and the bit index is set to 0.
  - DATA: on every tick where `cnt`==OVERSAMPLE−1, shift `rx_s` into the MSB of the shift register (LSB-first reception) and increment the bit index. After DATA_BITS samples, go to STOP.
  - STOP: on the tick where `cnt`==OVERSAMPLE−1:
    - `rx_s`=1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
    - `rx_s`=0: pulse `frame_err`, leave `rx_data` unchanged, go to BREAK.
  - BREAK: wait for a tick with `rx_s`=1, then go to IDLE. This stops a held-low line (break) from retriggering.
- Returning to IDLE at mid-stop, rather than at the end of the stop bit, gives ±half-bit tolerance to back-to-back frames.
- `rx_valid` and `frame_err` are never high in the same cycle.
- Reset asserted mid-frame aborts the frame immediately: no `rx_valid` or `frame_err` pulse.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0, state IDLE.
- Let T0 be the first tick that sees `rx_s`=0 in IDLE.
- Sample points (in ticks after T0), for OVERSAMPLE=8 and DATA_BITS=8:
  - mid-start: T0+4
  - data bit k (k=0..7): T0+12+8k
  - stop bit: T0+76
- `rx_valid` or `frame_err` goes high in the clk cycle after the T0+76 tick edge and lasts exactly 1 clk.
- `rx` to `rx_s` adds 2 clk of synchroniser delay, which is negligible against the tick spacing.
- `busy` rises in the cycle after T0 and falls with the `rx_valid` pulse, or on leaving BREAK.

## Structure
- Shared package holds:
  - state encoding (IDLE, START, DATA, STOP, BREAK)
  - default OVERSAMPLE/DATA_BITS constants, shared with baud_generator's BAUD_DIV derivation
- One natural sub-module: `sync_2ff`, the reusable 2-flop synchroniser with a reset-value parameter.
- The FSM, counter and shift register stay in the top module, roughly 150–250 lines.

## Test plan
- Good frame: drive 0xA5 at tick-accurate 8N1 with `baud_tick` every 4 clk -> `rx_data`=0xA5, single `rx_valid` pulse at T0+76 ticks +1 clk, `frame_err` stays 0.
- Back-to-back frames: send 0x00 then 0xFF with no idle gap -> two `rx_valid` pulses, `rx_data` reads 0x00 then 0xFF.
- Glitch rejection: pull `rx` low for 2 ticks only -> state returns to IDLE at T0+4, no pulse; a following frame 0x3C is received correctly.
- Framing error: frame 0x55 with stop bit 0 -> `frame_err` 1-clk pulse, `rx_data` keeps its prior value, `busy` stays high until `rx` returns to 1.
- Break: hold `rx` low for 30 bit-times -> exactly one `frame_err`, no `rx_valid`; after release, 0x81 is received correctly.
- Reset mid-frame: assert `rst_n` low during data bit 3 of 0xC3 -> all outputs return to reset values immediately with no pulse; the next frame 0x12 is received correctly.
